// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encodings, default depth and BTB entry layout.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int BP_ENTRY_BITS = 5;

  // Tag is stored as pc[31:2] shifted down by ENTRY_BITS, so one width fits every depth.
  localparam int BP_TAG_W = 30;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    logic                is_branch;
  } btb_entry_t;

  function automatic ctr_e ctr_next(ctr_e c, logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_e'(c + 2'd1);
    end else begin
      if (c != SNT) n = ctr_e'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: async-reset valid bits, combinational read port, one registered write port.
module btb_table
  import bp_pkg::*;
#(
  parameter int ENTRY_BITS = BP_ENTRY_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ENTRY_BITS-1:0] rd_idx,
  output btb_entry_t            rd_entry,
  input  logic                  wr_en,
  input  logic [ENTRY_BITS-1:0] wr_idx,
  input  btb_entry_t            wr_entry
);

  localparam int DEPTH = 1 << ENTRY_BITS;

  logic                valid_q  [DEPTH];
  logic [BP_TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]         target_q [DEPTH];
  logic                branch_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
      branch_q[wr_idx] <= wr_entry.is_branch;
    end
  end

  always_comb begin
    rd_entry           = '0;
    rd_entry.valid     = valid_q[rd_idx];
    rd_entry.tag       = tag_q[rd_idx];
    rd_entry.target    = target_q[rd_idx];
    rd_entry.is_branch = branch_q[rd_idx];
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC predictor: BTB plus 2-bit PHT; gshare indexing when BP_GSHARE_EN is
// defined, bimodal otherwise.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRY_BITS = BP_ENTRY_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           current_pc,
  output logic [31:0]           pred_next_pc,
  output logic                  pred_taken,
  output logic [ENTRY_BITS-1:0] pred_ghr,
  input  logic                  update_valid,
  input  logic [31:0]           update_pc,
  input  logic [31:0]           update_target,
  input  logic                  update_taken,
  input  logic                  update_is_branch,
  input  logic [ENTRY_BITS-1:0] update_ghr
);

  localparam int DEPTH = 1 << ENTRY_BITS;

  logic [ENTRY_BITS-1:0] idx, pidx;
  logic [ENTRY_BITS-1:0] upd_idx, upd_pidx;
  logic [BP_TAG_W-1:0]   tag, upd_tag;
  btb_entry_t            rd_entry, wr_entry;
  logic                  hit;
  ctr_e                  pht_q [DEPTH];
  ctr_e                  ctr_rd;

  assign idx     = current_pc[ENTRY_BITS+1:2];
  assign tag     = current_pc[31:2] >> ENTRY_BITS;
  assign upd_idx = update_pc[ENTRY_BITS+1:2];
  assign upd_tag = update_pc[31:2] >> ENTRY_BITS;

  // Byte offset of word-aligned PCs carries no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{current_pc[1:0], update_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [ENTRY_BITS-1:0] ghr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (update_valid && update_is_branch) begin
      ghr_q <= {ghr_q[ENTRY_BITS-2:0], update_taken};
    end
  end

  assign pidx     = idx ^ ghr_q;
  assign upd_pidx = upd_idx ^ update_ghr;
  assign pred_ghr = ghr_q;
`else
  logic unused_update_ghr;
  assign unused_update_ghr = ^update_ghr;

  assign pidx     = idx;
  assign upd_pidx = upd_idx;
  assign pred_ghr = '0;
`endif

  // Update port: update_valid qualifies all update_* inputs for exactly one cycle; there is no
  // back-pressure, every valid update is absorbed at the next posedge (unless reset is high).
  always_comb begin
    wr_entry           = '0;
    wr_entry.valid     = 1'b1;
    wr_entry.tag       = upd_tag;
    wr_entry.target    = update_target;
    wr_entry.is_branch = update_is_branch;
  end

  btb_table #(
    .ENTRY_BITS(ENTRY_BITS)
  ) u_btb (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_entry (rd_entry),
    .wr_en    (update_valid && update_taken),
    .wr_idx   (upd_idx),
    .wr_entry (wr_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= WNT;
    end else if (update_valid && update_is_branch) begin
      pht_q[upd_pidx] <= ctr_next(pht_q[upd_pidx], update_taken);
    end
  end

  // Lookup reads registered state only, so a same-cycle update is seen one cycle later.
  assign ctr_rd       = pht_q[pidx];
  assign hit          = rd_entry.valid && (rd_entry.tag == tag);
  assign pred_taken   = hit && (!rd_entry.is_branch || (ctr_rd == WT) || (ctr_rd == ST));
  assign pred_next_pc = pred_taken ? rd_entry.target : current_pc + 32'd4;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRY_BITS=5); expectations follow BP_GSHARE_EN.
module tb_branch_predictor;

`ifdef BP_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] current_pc;
  logic [31:0] pred_next_pc;
  logic        pred_taken;
  logic [4:0]  pred_ghr;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_is_branch;
  logic [4:0]  update_ghr;

  branch_predictor #(.ENTRY_BITS(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .current_pc       (current_pc),
    .pred_next_pc     (pred_next_pc),
    .pred_taken       (pred_taken),
    .pred_ghr         (pred_ghr),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_target    (update_target),
    .update_taken     (update_taken),
    .update_is_branch (update_is_branch),
    .update_ghr       (update_ghr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        utk;
    logic        ubr;
    logic [4:0]  ughr;
    logic [31:0] pc;
    logic        etk;
    logic [31:0] enpc;
    logic [4:0]  eghr;
  } vec_t;

  vec_t       vecs[$];
  logic [37:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  function automatic vec_t mkv(string n, logic uv, logic [31:0] upc, logic [31:0] utgt,
                               logic utk, logic ubr, logic [4:0] ughr, logic [31:0] pc,
                               logic etk, logic [31:0] enpc, logic [4:0] eghr);
    vec_t v;
    v.name = n; v.uv = uv; v.upc = upc; v.utgt = utgt; v.utk = utk; v.ubr = ubr;
    v.ughr = ughr; v.pc = pc; v.etk = etk; v.enpc = enpc; v.eghr = eghr;
    return v;
  endfunction

  // driver tasks
  task automatic drive_upd(logic v, logic [31:0] pc, logic [31:0] tgt, logic tk, logic br,
                           logic [4:0] g);
    update_valid     = v;
    update_pc        = pc;
    update_target    = tgt;
    update_taken     = tk;
    update_is_branch = br;
    update_ghr       = g;
  endtask

  // scoreboard
  task automatic check(string name, logic etk, logic [31:0] enpc, logic [4:0] eghr);
    logic [37:0] e;
    exp_q.push_back({etk, enpc, eghr});
    e = exp_q.pop_front();
    checks++;
    if (pred_taken !== e[37]) begin
      errors++;
      $display("FAIL %s.taken: got %0b expected %0b", name, pred_taken, e[37]);
    end
    checks++;
    if (pred_next_pc !== e[36:5]) begin
      errors++;
      $display("FAIL %s.next_pc: got %h expected %h", name, pred_next_pc, e[36:5]);
    end
    checks++;
    if (pred_ghr !== e[4:0]) begin
      errors++;
      $display("FAIL %s.ghr: got %b expected %b", name, pred_ghr, e[4:0]);
    end
  endtask

  initial begin
    // Each vector: drive lookup + update, check outputs (pre-edge state), then clock the edge.
    vecs.push_back(mkv("reset",      0, 32'h0,   32'h0,  0, 0, 5'd0, 32'h100, 0, 32'h104, 5'd0));
    vecs.push_back(mkv("no_bypass",  1, 32'h20,  32'h80, 1, 0, 5'd0, 32'h20,  0, 32'h24,  5'd0));
    vecs.push_back(mkv("jal_hit",    0, 32'h0,   32'h0,  0, 0, 5'd0, 32'h20,  1, 32'h80,  5'd0));
    vecs.push_back(mkv("alias_miss", 0, 32'h0,   32'h0,  0, 0, 5'd0, 32'hA0,  0, 32'hA4,  5'd0));
    vecs.push_back(mkv("pc_wrap",    0, 32'h0,   32'h0,  0, 0, 5'd0, 32'hFFFF_FFFC, 0, 32'h0, 5'd0));
    vecs.push_back(mkv("br_train",   1, 32'h40,  32'h10, 1, 1, 5'd0, 32'h100, 0, 32'h104, 5'd0));
    vecs.push_back(mkv("br_look",    0, 32'h0,   32'h0,  0, 0, 5'd0, 32'h40,
                       GS ? 1'b0 : 1'b1, GS ? 32'h44 : 32'h10, GS ? 5'd1 : 5'd0));
    vecs.push_back(mkv("nt1",        1, 32'h40,  32'h10, 0, 1, 5'd0, 32'h40,
                       GS ? 1'b0 : 1'b1, GS ? 32'h44 : 32'h10, GS ? 5'd1 : 5'd0));
    vecs.push_back(mkv("nt2",        1, 32'h40,  32'h10, 0, 1, 5'd0, 32'h40, 0, 32'h44,
                       GS ? 5'd2 : 5'd0));
    vecs.push_back(mkv("nt3",        1, 32'h40,  32'h10, 0, 1, 5'd0, 32'h40, 0, 32'h44,
                       GS ? 5'd4 : 5'd0));
    vecs.push_back(mkv("nt4",        1, 32'h40,  32'h10, 0, 1, 5'd0, 32'h40, 0, 32'h44,
                       GS ? 5'd8 : 5'd0));
    vecs.push_back(mkv("tk5",        1, 32'h40,  32'h10, 1, 1, 5'd0, 32'h40, 0, 32'h44,
                       GS ? 5'd16 : 5'd0));
    vecs.push_back(mkv("shift1",     1, 32'h300, 32'h0,  0, 1, 5'd1, 32'h100, 0, 32'h104,
                       GS ? 5'd1 : 5'd0));
    vecs.push_back(mkv("shift2",     1, 32'h300, 32'h0,  0, 1, 5'd1, 32'h100, 0, 32'h104,
                       GS ? 5'd2 : 5'd0));
    vecs.push_back(mkv("shift3",     1, 32'h300, 32'h0,  0, 1, 5'd1, 32'h100, 0, 32'h104,
                       GS ? 5'd4 : 5'd0));
    vecs.push_back(mkv("shift4",     1, 32'h300, 32'h0,  0, 1, 5'd1, 32'h100, 0, 32'h104,
                       GS ? 5'd8 : 5'd0));
    vecs.push_back(mkv("shift5",     1, 32'h300, 32'h0,  0, 1, 5'd1, 32'h100, 0, 32'h104,
                       GS ? 5'd16 : 5'd0));
    // pht[0x10] must be back at 2'b01 after saturating at 2'b00.
    vecs.push_back(mkv("sat_check",  0, 32'h0,   32'h0,  0, 0, 5'd0, 32'h40, 0, 32'h44, 5'd0));

    reset      = 1'b1;
    current_pc = 32'h0;
    drive_upd(0, 32'h0, 32'h0, 0, 0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      current_pc = vecs[i].pc;
      drive_upd(vecs[i].uv, vecs[i].upc, vecs[i].utgt, vecs[i].utk, vecs[i].ubr, vecs[i].ughr);
      #1;
      check(vecs[i].name, vecs[i].etk, vecs[i].enpc, vecs[i].eghr);
      @(posedge clk);
      #1;
    end

    // Mid-cycle reset with a pending update to 0x60.
    current_pc = 32'h100;
    drive_upd(1, 32'h40, 32'h10, 1, 1, 5'd0);
    @(posedge clk);
    #1;
    current_pc = 32'h20;
    drive_upd(1, 32'h60, 32'h500, 1, 0, 5'd0);
    #1;
    check("pre_reset", 1, 32'h80, GS ? 5'd1 : 5'd0);
    #1;
    reset = 1'b1;
    #1;
    check("reset_now", 0, 32'h24, 5'd0);
    @(posedge clk);
    #1;
    drive_upd(0, 32'h0, 32'h0, 0, 0, 5'd0);
    #2;
    reset = 1'b0;
    current_pc = 32'h60;
    #1;
    check("dropped_upd", 0, 32'h64, 5'd0);

    // First update after release is captured at the next edge.
    drive_upd(1, 32'h60, 32'h500, 1, 0, 5'd0);
    @(posedge clk);
    #1;
    drive_upd(0, 32'h0, 32'h0, 0, 0, 5'd0);
    current_pc = 32'h60;
    #1;
    check("post_release", 1, 32'h500, 5'd0);

    // GHR and PHT restart from reset values.
    current_pc = 32'h100;
    drive_upd(1, 32'h40, 32'h10, 1, 1, 5'd0);
    @(posedge clk);
    #1;
    drive_upd(0, 32'h0, 32'h0, 0, 0, 5'd0);
    current_pc = 32'h40;
    #1;
    check("ghr_restart", GS ? 1'b0 : 1'b1, GS ? 32'h44 : 32'h10, GS ? 5'd1 : 5'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
